// File: rtl/sb_pkg.sv
// rtl/sb_pkg.sv - shared constants, state types and CRC-16 helper for the sideband receiver
package sb_pkg;

    localparam logic [7:0] DLE = 8'hFE;
    localparam logic [7:0] STX = 8'h02;
    localparam logic [7:0] ETX = 8'h40;

    // Bit-reverse a 16-bit word; used to turn the normal polynomial into its LSB-first form
    function automatic logic [15:0] reverse16(input logic [15:0] v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[i] = v[15 - i];
        end
        return r;
    endfunction

    localparam logic [15:0] CRC_POLY      = 16'h8005;
    localparam logic [15:0] CRC_POLY_REFL = reverse16(CRC_POLY);
    localparam logic [15:0] CRC_INIT      = 16'hFFFF;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    typedef enum logic [2:0] {
        P_IDLE,
        P_DLE,
        P_LT,
        P_AT,
        P_AT_DLE
    } parser_state_t;

    // One byte of LSB-first CRC-16 (register kept bit-reversed, so the reflected polynomial applies)
    function automatic logic [15:0] crc16_update(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/sb_uart_rx.sv
// rtl/sb_uart_rx.sv - sbrx synchronizer and one-bit-per-cycle symbol receiver
module sb_uart_rx
    import sb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       sbrx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       framing_err
);

    logic [1:0] sync;
    logic       s;
    rx_state_t  state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;

    assign s = sync[1];

    // Two-flop synchronizer; resets to the idle-high line level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], sbrx};
        end
    end

    // Symbol FSM: start bit, 8 data bits LSB first, stop bit; bad stop waits in BREAK for a 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RX_IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            byte_data   <= '0;
            byte_valid  <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            byte_valid  <= 1'b0;
            framing_err <= 1'b0;
            if (!enable) begin
                state <= RX_IDLE;
            end else begin
                case (state)
                    RX_IDLE: begin
                        if (!s) begin
                            state   <= RX_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    RX_DATA: begin
                        shreg   <= {s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= RX_STOP;
                        end
                    end
                    RX_STOP: begin
                        if (s) begin
                            byte_data  <= shreg;
                            byte_valid <= 1'b1;
                            state      <= RX_IDLE;
                        end else begin
                            framing_err <= 1'b1;
                            state       <= RX_BREAK;
                        end
                    end
                    default: begin
                        if (s) begin
                            state <= RX_IDLE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/sideband_rx_framer.sv
// rtl/sideband_rx_framer.sv - sideband LT/AT frame parser; define SB_CRC_CHECK_EN to check the AT CRC-16
module sideband_rx_framer
    import sb_pkg::*;
#(
    parameter int MAX_LEN = 32
) (
    input  logic       sb_clk,
    input  logic       rst,
    input  logic       sbrx,
    input  logic       enable,
    output logic       lt_valid,
    output logic [7:0] lt_lse,
    output logic [7:0] at_data,
    output logic       at_valid,
    output logic       at_sop,
    output logic       at_eop,
    output logic       at_err,
    output logic       framing_err
);

    localparam int CNT_W = $clog2(MAX_LEN + 4);

    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          rx_ferr;

    parser_state_t pstate;
    logic [7:0]    lse;
    logic [7:0]    body0;
    logic [7:0]    body1;
    logic [7:0]    body2;
    logic [1:0]    fill;
    logic [CNT_W-1:0] body_cnt;
    logic          sop_pending;
    logic          push_req;
    logic          overflow;
`ifdef SB_CRC_CHECK_EN
    logic [15:0]   crc;
`endif

    sb_uart_rx u_uart (
        .clk         (sb_clk),
        .rst         (rst),
        .enable      (enable),
        .sbrx        (sbrx),
        .byte_data   (rx_byte),
        .byte_valid  (rx_valid),
        .framing_err (rx_ferr)
    );

    // An unstuffed body byte arrives: plain byte in P_AT or the second DLE of a stuffed pair
    always_comb begin
        push_req = 1'b0;
        if (rx_valid && enable) begin
            if (pstate == P_AT && rx_byte != DLE) begin
                push_req = 1'b1;
            end
            if (pstate == P_AT_DLE && rx_byte == DLE) begin
                push_req = 1'b1;
            end
        end
    end

    assign overflow = push_req && (body_cnt == CNT_W'(MAX_LEN + 2));

    // Frame parser with a 3-byte hold-back buffer so the trailing CRC bytes are never emitted
    always_ff @(posedge sb_clk or posedge rst) begin
        if (rst) begin
            pstate      <= P_IDLE;
            lse         <= '0;
            body0       <= '0;
            body1       <= '0;
            body2       <= '0;
            fill        <= '0;
            body_cnt    <= '0;
            sop_pending <= 1'b0;
`ifdef SB_CRC_CHECK_EN
            crc         <= CRC_INIT;
`endif
            lt_valid    <= 1'b0;
            lt_lse      <= '0;
            at_data     <= '0;
            at_valid    <= 1'b0;
            at_sop      <= 1'b0;
            at_eop      <= 1'b0;
            at_err      <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            lt_valid    <= 1'b0;
            at_valid    <= 1'b0;
            at_sop      <= 1'b0;
            at_eop      <= 1'b0;
            at_err      <= 1'b0;
            framing_err <= 1'b0;
            if (!enable) begin
                pstate <= P_IDLE;
                fill   <= '0;
            end else if (rx_ferr) begin
                framing_err <= 1'b1;
                at_err      <= (pstate == P_AT) || (pstate == P_AT_DLE);
                pstate      <= P_IDLE;
                fill        <= '0;
            end else if (rx_valid) begin
                case (pstate)
                    P_IDLE: begin
                        if (rx_byte == DLE) begin
                            pstate <= P_DLE;
                        end
                    end
                    P_DLE: begin
                        if (rx_byte == STX) begin
                            pstate      <= P_AT;
                            fill        <= '0;
                            body_cnt    <= '0;
                            sop_pending <= 1'b1;
`ifdef SB_CRC_CHECK_EN
                            crc         <= CRC_INIT;
`endif
                        end else if (rx_byte == DLE || rx_byte == ETX) begin
                            pstate <= P_IDLE;
                        end else begin
                            lse    <= rx_byte;
                            pstate <= P_LT;
                        end
                    end
                    P_LT: begin
                        if (rx_byte == ~lse) begin
                            lt_valid <= 1'b1;
                            lt_lse   <= lse;
                        end else begin
                            framing_err <= 1'b1;
                        end
                        pstate <= P_IDLE;
                    end
                    P_AT: begin
                        if (rx_byte == DLE) begin
                            pstate <= P_AT_DLE;
                        end
                    end
                    P_AT_DLE: begin
                        if (rx_byte == DLE) begin
                            pstate <= P_AT;
                        end else if (rx_byte == ETX) begin
                            if (fill == 2'd3) begin
                                at_valid <= 1'b1;
                                at_data  <= body0;
                                at_sop   <= sop_pending;
                                at_eop   <= 1'b1;
`ifdef SB_CRC_CHECK_EN
                                at_err   <= (crc16_update(crc, body0) != {body2, body1});
`endif
                            end else begin
                                at_err <= 1'b1;
                            end
                            sop_pending <= 1'b0;
                            fill        <= '0;
                            pstate      <= P_IDLE;
                        end else if (rx_byte == STX) begin
                            at_err      <= 1'b1;
                            fill        <= '0;
                            body_cnt    <= '0;
                            sop_pending <= 1'b1;
`ifdef SB_CRC_CHECK_EN
                            crc         <= CRC_INIT;
`endif
                            pstate      <= P_AT;
                        end else begin
                            at_err <= 1'b1;
                            fill   <= '0;
                            pstate <= P_IDLE;
                        end
                    end
                    default: begin
                        pstate <= P_IDLE;
                    end
                endcase

                if (push_req) begin
                    if (overflow) begin
                        at_err <= 1'b1;
                        fill   <= '0;
                        pstate <= P_IDLE;
                    end else begin
                        body_cnt <= body_cnt + 1'b1;
                        case (fill)
                            2'd0: begin
                                body0 <= rx_byte;
                                fill  <= 2'd1;
                            end
                            2'd1: begin
                                body1 <= rx_byte;
                                fill  <= 2'd2;
                            end
                            2'd2: begin
                                body2 <= rx_byte;
                                fill  <= 2'd3;
                            end
                            default: begin
                                at_valid    <= 1'b1;
                                at_data     <= body0;
                                at_sop      <= sop_pending;
                                sop_pending <= 1'b0;
`ifdef SB_CRC_CHECK_EN
                                crc         <= crc16_update(crc, body0);
`endif
                                body0       <= body1;
                                body1       <= body2;
                                body2       <= rx_byte;
                            end
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sideband_rx_framer.sv
// tb/tb_sideband_rx_framer.sv - randomized scoreboard bench for sideband_rx_framer
module tb_sideband_rx_framer;

    localparam int MAX_LEN = 32;
`ifdef SB_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic       sb_clk = 1'b0;
    logic       rst = 1'b1;
    logic       sbrx = 1'b1;
    logic       enable = 1'b1;
    logic       lt_valid;
    logic [7:0] lt_lse;
    logic [7:0] at_data;
    logic       at_valid;
    logic       at_sop;
    logic       at_eop;
    logic       at_err;
    logic       framing_err;

    sideband_rx_framer #(.MAX_LEN(MAX_LEN)) dut (
        .sb_clk      (sb_clk),
        .rst         (rst),
        .sbrx        (sbrx),
        .enable      (enable),
        .lt_valid    (lt_valid),
        .lt_lse      (lt_lse),
        .at_data     (at_data),
        .at_valid    (at_valid),
        .at_sop      (at_sop),
        .at_eop      (at_eop),
        .at_err      (at_err),
        .framing_err (framing_err)
    );

    always #5 sb_clk = ~sb_clk;

    typedef struct packed {
        logic       lt_v;
        logic [7:0] lse;
        logic       at_v;
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic       err;
        logic       ferr;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  failures = 0;

    // CRC-16/0x8005 reference: MSB-first register on bit-reversed input, result reflected
    function automatic logic [15:0] crc_model(input logic [7:0] p[$]);
        logic [15:0] r;
        logic [15:0] o;
        logic [7:0]  rb;
        r = 16'hFFFF;
        foreach (p[i]) begin
            for (int k = 0; k < 8; k++) rb[k] = p[i][7 - k];
            r = r ^ {rb, 8'h00};
            for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h8005) : (r << 1);
        end
        for (int k = 0; k < 16; k++) o[k] = r[15 - k];
        return o;
    endfunction

    task automatic exp_lt(input logic [7:0] x);
        ev_t e;
        e = '0; e.lt_v = 1'b1; e.lse = x;
        exp_q.push_back(e);
    endtask

    task automatic exp_ferr(input logic aterr);
        ev_t e;
        e = '0; e.ferr = 1'b1; e.err = aterr;
        exp_q.push_back(e);
    endtask

    task automatic exp_byte(input logic [7:0] d, input logic sop, input logic eop, input logic err);
        ev_t e;
        e = '0; e.at_v = 1'b1; e.data = d; e.sop = sop; e.eop = eop; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic exp_err();
        ev_t e;
        e = '0; e.err = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic send_bit(input logic b);
        sbrx = b;
        @(posedge sb_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        if (!stop) repeat (2) send_bit(1'b1);
        repeat ($urandom_range(0, 2)) send_bit(1'b1);
    endtask

    task automatic send_stuffed(input logic [7:0] q[$]);
        foreach (q[i]) begin
            send_byte(q[i]);
            if (q[i] == 8'hFE) send_byte(8'hFE);
        end
    endtask

    // Expected outcome of an AT frame from its unstuffed body (payload followed by two CRC bytes)
    task automatic send_at_body(input logic [7:0] body[$]);
        logic [7:0] pay[$];
        int n;
        n = body.size();
        if (n > MAX_LEN + 2) begin
            // MAX_LEN+2 bytes are accepted and the last 3 of them are still held when it aborts
            for (int i = 0; i < MAX_LEN - 1; i++) exp_byte(body[i], i == 0, 1'b0, 1'b0);
            exp_err();
        end else if (n < 3) begin
            exp_err();
        end else begin
            for (int i = 0; i < n - 2; i++) pay.push_back(body[i]);
            for (int i = 0; i < n - 2; i++)
                exp_byte(body[i], i == 0, i == n - 3,
                         (i == n - 3) && CRC_EN && (crc_model(pay) != {body[n-1], body[n-2]}));
        end
        send_byte(8'hFE);
        send_byte(8'h02);
        send_stuffed(body);
        send_byte(8'hFE);
        send_byte(8'h40);
    endtask

    task automatic send_at(input logic [7:0] pay[$], input bit bad_crc);
        logic [7:0]  body[$];
        logic [15:0] c;
        c = crc_model(pay);
        body = pay;
        body.push_back(c[7:0] ^ {7'd0, bad_crc});
        body.push_back(c[15:8]);
        send_at_body(body);
    endtask

    task automatic rand_payload(input int n, output logic [7:0] p[$]);
        p = {};
        for (int i = 0; i < n; i++) p.push_back(($urandom_range(0, 7) == 0) ? 8'hFE : 8'($urandom));
    endtask

    function automatic logic [7:0] rand_lse();
        logic [7:0] x;
        do x = 8'($urandom); while (x == 8'hFE || x == 8'h02 || x == 8'h40);
        return x;
    endfunction

    task automatic check_quiet(input string name);
        @(negedge sb_clk);
        checks++;
        if ({lt_valid, lt_lse, at_data, at_valid, at_sop, at_eop, at_err, framing_err} != '0) begin
            failures++;
            $display("FAIL %s: outputs lt=%0b lse=%02h data=%02h v=%0b sop=%0b eop=%0b err=%0b ferr=%0b, required all 0",
                     name, lt_valid, lt_lse, at_data, at_valid, at_sop, at_eop, at_err, framing_err);
        end
    endtask

    // Monitor: every strobe the DUT presents is matched against the next expected event
    always @(negedge sb_clk) begin : monitor
        ev_t  e;
        logic ok;
        if (!rst && (lt_valid || at_valid || at_err || framing_err)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe: lt=%0b at_v=%0b data=%02h err=%0b ferr=%0b, required no strobe",
                         lt_valid, at_valid, at_data, at_err, framing_err);
            end else begin
                e = exp_q.pop_front();
                ok = (lt_valid == e.lt_v) && (at_valid == e.at_v) && (at_sop == e.sop) &&
                     (at_eop == e.eop) && (at_err == e.err) && (framing_err == e.ferr) &&
                     (!e.lt_v || lt_lse == e.lse) && (!e.at_v || at_data == e.data);
                if (!ok) begin
                    failures++;
                    $display("FAIL event: got lt=%0b lse=%02h v=%0b d=%02h sop=%0b eop=%0b err=%0b ferr=%0b, required lt=%0b lse=%02h v=%0b d=%02h sop=%0b eop=%0b err=%0b ferr=%0b",
                             lt_valid, lt_lse, at_valid, at_data, at_sop, at_eop, at_err, framing_err,
                             e.lt_v, e.lse, e.at_v, e.data, e.sop, e.eop, e.err, e.ferr);
                end
            end
        end
    end

    initial begin
        logic [7:0] p[$];
        logic [7:0] body[$];
        logic [7:0] x;
        logic [7:0] y;
        int kind;
        int n;

        repeat (4) @(posedge sb_clk);
        check_quiet("reset_state");
        @(posedge sb_clk); #1;
        rst = 1'b0;
        repeat (4) send_bit(1'b1);

        // Good LT and LT with bad complement
        exp_lt(8'h11);
        send_byte(8'hFE); send_byte(8'h11); send_byte(8'hEE);
        exp_ferr(1'b0);
        send_byte(8'hFE); send_byte(8'h11); send_byte(8'hEF);

        // AT with stuffed DLE in payload: good CRC, then corrupted CRC low byte
        p = '{8'hA5, 8'hFE, 8'h3C};
        send_at(p, 1'b0);
        send_at(p, 1'b1);

        // Bad stop bit mid-AT aborts the frame; the following LT is still accepted
        exp_byte(8'hA5, 1'b1, 1'b0, 1'b0);
        exp_ferr(1'b1);
        send_byte(8'hFE); send_byte(8'h02);
        send_byte(8'hA5); send_byte(8'hB6); send_byte(8'hC7); send_byte(8'hD8);
        send_byte(8'h77, 1'b0);
        exp_lt(8'h22);
        send_byte(8'hFE); send_byte(8'h22); send_byte(8'hDD);

        // Short body, overlong body, abort by DLE+other, restart by DLE+STX
        body = '{8'h12, 8'h34};
        send_at_body(body);
        rand_payload(MAX_LEN + 1, p);
        send_at(p, 1'b0);
        exp_byte(8'h11, 1'b1, 1'b0, 1'b0);
        exp_err();
        send_byte(8'hFE); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'hFE); send_byte(8'h55);
        exp_err();
        send_byte(8'hFE); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
        p = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_at(p, 1'b0);

        // Enable low drops a partial frame silently
        send_byte(8'hFE); send_byte(8'h02); send_byte(8'hA1); send_byte(8'hB2);
        enable = 1'b0;
        repeat (5) send_bit(1'b1);
        enable = 1'b1;
        repeat (2) send_bit(1'b1);
        p = '{8'h5A, 8'h6B};
        send_at(p, 1'b0);

        // Reset mid-frame after some payload was emitted
        send_byte(8'hFE); send_byte(8'h02);
        for (int i = 0; i < 10; i++) begin
            if (i < 7) exp_byte(8'h30 + 8'(i), i == 0, 1'b0, 1'b0);
            send_byte(8'h30 + 8'(i));
        end
        repeat (6) send_bit(1'b1);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        #3 rst = 1'b1;
        sbrx = 1'b1;
        check_quiet("reset_midframe");
        repeat (3) @(posedge sb_clk);
        #1 rst = 1'b0;
        repeat (3) send_bit(1'b1);
        p = '{8'hC0, 8'hFE, 8'hDE, 8'h01};
        send_at(p, 1'b0);

        // Randomized traffic
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 6);
            case (kind)
                0: begin
                    x = rand_lse();
                    exp_lt(x);
                    send_byte(8'hFE); send_byte(x); send_byte(~x);
                end
                1: begin
                    x = rand_lse();
                    y = ~x ^ (8'h01 << $urandom_range(0, 7));
                    exp_ferr(1'b0);
                    send_byte(8'hFE); send_byte(x); send_byte(y);
                end
                2: begin
                    rand_payload($urandom_range(1, MAX_LEN), p);
                    send_at(p, 1'b0);
                end
                3: begin
                    rand_payload($urandom_range(1, 8), p);
                    send_at(p, 1'b1);
                end
                4: begin
                    rand_payload($urandom_range(0, 2), body);
                    send_at_body(body);
                end
                5: begin
                    rand_payload($urandom_range(MAX_LEN + 1, MAX_LEN + 3), p);
                    send_at(p, 1'b0);
                end
                default: begin
                    n = $urandom_range(0, 6);
                    rand_payload(n, body);
                    for (int i = 0; i < n - 3; i++) exp_byte(body[i], i == 0, 1'b0, 1'b0);
                    exp_err();
                    send_byte(8'hFE); send_byte(8'h02);
                    send_stuffed(body);
                    send_byte(8'hFE);
                    send_byte(8'($urandom_range(8'h41, 8'hFD)));
                end
            endcase
            repeat ($urandom_range(0, 4)) send_bit(1'b1);
        end

        for (int t = 0; t < 400 && exp_q.size() != 0; t++) @(posedge sb_clk);
        repeat (4) @(posedge sb_clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d events still outstanding, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sideband_rx_framer.md
SIDEBAND_RX_FRAMER -- requirements
Module: sideband_rx_framer

Interface
REQ-001 Parameter MAX_LEN, default 32, maximum AT payload bytes (CRC excluded).
REQ-002 sb_clk  in  1  sideband clock, one bit time per cycle; sole clock.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 sbrx  in  1  serial sideband input, idle high.
REQ-005 enable  in  1  receiver enable.
REQ-006 lt_valid  out  1  one-cycle pulse, LT transaction received.
REQ-007 lt_lse  out  8  LSE byte of last LT transaction.
REQ-008 at_data  out  8  AT payload byte, valid with at_valid.
REQ-009 at_valid / at_sop / at_eop  out  1 each  payload strobe, first byte, last byte.
REQ-010 at_err  out  1  one-cycle pulse, AT abort or CRC failure.
REQ-011 framing_err  out  1  one-cycle pulse, bad stop bit or bad LT complement.

Function
REQ-012 sbrx passes a 2-flop synchronizer before use.
REQ-013 Symbol receiver states IDLE, DATA, STOP, BREAK: IDLE->DATA on sampled 0; 8 bits LSB first, one per cycle; STOP samples 1 -> byte strobe next cycle, else framing_err, ->BREAK until a 1 is sampled.
REQ-014 Parser states P_IDLE, P_DLE, P_LT, P_AT, P_AT_DLE; constants DLE=0xFE, STX=0x02, ETX=0x40.
REQ-015 P_IDLE: DLE->P_DLE; other bytes dropped.
REQ-016 P_DLE: STX->P_AT (clear length, CRC); DLE or ETX->P_IDLE; other byte latched as LSE->P_LT.
REQ-017 P_LT: byte == ~LSE -> lt_valid, lt_lse updated; else framing_err; both ->P_IDLE.
REQ-018 P_AT: DLE->P_AT_DLE; other byte pushed into body buffer.
REQ-019 P_AT_DLE: DLE -> push 0xFE, ->P_AT; ETX -> end of frame; STX -> abort (at_err), restart new AT in P_AT; other -> abort (at_err), ->P_IDLE.
REQ-020 Body buffer is 3 bytes deep; pushing a 4th unstuffed byte emits the oldest as at_valid one cycle after the pushing strobe; first emitted byte carries at_sop.
REQ-021 At ETX: oldest buffered byte emitted with at_eop; remaining two bytes are the CRC (low byte first), never emitted.
REQ-022 End with fewer than 3 body bytes -> at_err only, no at_valid.
REQ-023 Body exceeding MAX_LEN+2 bytes -> abort with at_err, ->P_IDLE, remaining bytes dropped until next DLE STX.
REQ-024 After abort, at_eop is never issued for that frame; consumer discards from last at_sop.
REQ-025 framing_err during P_AT/P_AT_DLE aborts the frame (at_err same cycle) ->P_IDLE.
REQ-026 enable low: both FSMs forced to idle states, buffer cleared, all strobes 0; in-progress frame lost silently.

Reset
REQ-027 rst forces synchronizer to 1, symbol FSM IDLE, parser P_IDLE, buffer empty, lt_lse 0x00, all outputs 0.
REQ-028 Reset mid-frame produces no strobes; first frame after release is fully parsed.

Configuration
REQ-029 Macro SB_CRC_CHECK_EN defined: CRC-16 poly 0x8005, init 0xFFFF, LSB-first, no final XOR, over emitted payload bytes; mismatch at ETX -> at_err asserted with at_eop.
REQ-030 SB_CRC_CHECK_EN undefined: no CRC logic; CRC bytes still stripped; at_err never set by CRC.

Structure
REQ-031 Package sb_pkg holds DLE/STX/ETX constants, parser state enum, CRC polynomial/init.
REQ-032 Sub-module sb_uart_rx implements synchronizer and symbol FSM (REQ-012/013), outputs byte and byte strobe, framing_err.

Verification
REQ-033 Serialize FE 0x11 0xEE -> one lt_valid, lt_lse=0x11, no framing_err.
REQ-034 FE 0x11 0xEF -> framing_err pulse, no lt_valid.
REQ-035 FE 02 0xA5 FE FE 0x3C crc_lo crc_hi FE 40 (bench-model CRC) -> at_data A5(sop), FE, 3C(eop), no at_err.
REQ-036 Same frame, crc_lo XOR 0x01 -> with SB_CRC_CHECK_EN at_err with eop; without, no at_err.
REQ-037 Frame byte with stop bit 0 mid-AT -> framing_err and at_err same cycle, no eop; next valid LT accepted.
REQ-038 AT with 35 body bytes (MAX_LEN=32) -> at_err on 35th byte; rst asserted mid-frame -> all outputs 0, next frame correct.
